// File: rtl/bcd_timer_counter_if.sv
// Control and data bundle between the timer counter and its driver/display side.
interface bcd_timer_counter_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  Cen;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   disp;
    logic                  held;
    logic                  tc;

    modport master (
        output Cen, up, load, load_val, lap,
        input  count, disp, held, tc
    );

    modport slave (
        input  Cen, up, load, load_val, lap,
        output count, disp, held, tc
    );
endinterface

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up/down stopwatch counter with preset load, wrap/saturate
// limits, terminal-count pulse and lap (display freeze).
module bcd_timer_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input logic                msclk,
    input logic                reset,
    bcd_timer_counter_if.slave bus
);
    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] MaxVal = {DIGITS{4'h9}};

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] snap_q;
    logic         held_q;
    logic         tc_q, tc_d;
    logic [W-1:0] load_clamped;
    logic [W-1:0] step_val;
    logic [W-1:0] limit;
    logic         at_limit;
    logic         chain;

    always_comb begin
        load_clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped[4*k +: 4] = (bus.load_val[4*k +: 4] > 4'd9) ? 4'd9
                                                                      : bus.load_val[4*k +: 4];
        end
    end

    // Per-digit mod-10 step; chain carries (up) or borrows (down) toward the MSD.
    always_comb begin
        step_val = count_q;
        chain    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (chain) begin
                if (bus.up) begin
                    if (count_q[4*k +: 4] == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                        chain              = 1'b0;
                    end
                end else begin
                    if (count_q[4*k +: 4] == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                        chain              = 1'b0;
                    end
                end
            end
        end
    end

    assign limit    = bus.up ? MaxVal : '0;
    assign at_limit = (count_q == limit);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (bus.Cen) begin
            if (WRAP) begin
                count_d = step_val;
                tc_d    = at_limit;
            end else if (!at_limit) begin
                // Saturating: pulse on arrival, then freeze until reversal or load.
                count_d = step_val;
                tc_d    = (step_val == limit);
            end
        end
    end

    always_ff @(posedge msclk) begin
        if (!reset) begin
            count_q <= '0;
            snap_q  <= '0;
            held_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            if (bus.lap) begin
                if (!held_q) begin
                    snap_q <= count_q;
                    held_q <= 1'b1;
                end else begin
                    held_q <= 1'b0;
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.disp  = held_q ? snap_q : count_q;
    assign bus.held  = held_q;
    assign bus.tc    = tc_q;
endmodule
